// File: rtl/cancel_req_sequencer_pkg.sv
// Shared types for the cancel-request sequencer and the cancelled-order cache
// it feeds.
//   cpu_req_type    : request into the cache FSM (addr, data, rw, valid)
//   cpu_result_type : cache response (data, one-cycle ready strobe)
//   seq_entry_t     : buffered event {is_query, client_id, qty}; the ID field is
//                     sized for the widest legal client ID and zero-extended
//   seq_state_t     : sequencer FSM states
package cancel_req_sequencer_pkg;

  localparam int SEQ_IDW_MAX = 30;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic                   is_query;
    logic [SEQ_IDW_MAX-1:0] client_id;
    logic [31:0]            qty;
  } seq_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} seq_state_t;

  // Client ID lands on word-aligned addresses: ID bits become addr[31:2].
  function automatic logic [31:0] seq_addr(input logic [SEQ_IDW_MAX-1:0] id);
    return {id, 2'b00};
  endfunction

endpackage

// File: rtl/cancel_req_sequencer_fifo.sv
// seq_fifo: synchronous register-array FIFO, no bypass.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push, din : write strobe/data, ignored when full
//   pop, dout : read strobe, head entry (valid while !empty)
//   full, empty, count : occupancy status, count is log2(DEPTH)+1 bits
module seq_fifo #(
  parameter int DEPTH = 8,
  parameter type T = logic [7:0],
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  T            mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic        do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[head];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cancel_req_sequencer.sv
// cancel_req_sequencer: buffers cancel events / balance queries and replays
// them one at a time onto the cache FSM request port.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : event handshake (in_ready = FIFO not full)
//   in_is_query         : 1 = read balance, 0 = accumulate qty
//   in_client_id, in_qty: event payload
//   cpu_req / cpu_res   : cache request, cache result (ready is a strobe)
//   rd_valid/rd_client_id/rd_data : one-cycle query result
//   busy                : work queued or in flight
//   stall_err           : sticky, a request waited STALL_LIMIT cycles
//   done_cnt            : completed transactions, wraps
module cancel_req_sequencer
  import cancel_req_sequencer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int IDW         = 10,
  parameter int STALL_LIMIT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_is_query,
  input  logic [IDW-1:0] in_client_id,
  input  logic [31:0]    in_qty,
  output cpu_req_type    cpu_req,
  input  cpu_result_type cpu_res,
  output logic           rd_valid,
  output logic [IDW-1:0] rd_client_id,
  output logic [31:0]    rd_data,
  output logic           busy,
  output logic           stall_err,
  output logic [31:0]    done_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SCW = $clog2(STALL_LIMIT + 1);

  seq_state_t     state_q, state_d;
  seq_entry_t     in_entry, head_entry;
  logic           push, pop, full, empty;
  logic [AW:0]    fifo_cnt;
  cpu_req_type    req_q;
  logic           cur_query_q;
  logic [IDW-1:0] cur_id_q;
  logic [SCW-1:0] stall_cnt;

  always_comb begin
    in_entry           = '0;
    in_entry.is_query  = in_is_query;
    in_entry.client_id = SEQ_IDW_MAX'(in_client_id);
    in_entry.qty       = in_qty;
  end

  assign in_ready = !full;
  assign push     = in_valid && !full;

  seq_fifo #(.DEPTH(DEPTH), .T(seq_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DONE exists only to give the cache one cycle of valid=0 between
  // transactions so it cannot re-trigger on a stale request.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (cpu_res.ready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      cur_query_q  <= 1'b0;
      cur_id_q     <= '0;
      rd_valid     <= 1'b0;
      rd_client_id <= '0;
      rd_data      <= '0;
      done_cnt     <= '0;
      stall_cnt    <= '0;
      stall_err    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      // addr/rw/data are only loaded here, so they hold for the whole window.
      if (pop) begin
        req_q.addr  <= seq_addr(head_entry.client_id);
        req_q.rw    <= !head_entry.is_query;
        req_q.data  <= head_entry.is_query ? 32'd0 : head_entry.qty;
        req_q.valid <= 1'b1;
        cur_query_q <= head_entry.is_query;
        cur_id_q    <= head_entry.client_id[IDW-1:0];
        stall_cnt   <= '0;
      end
      // ready outside ISSUE is deliberately ignored.
      if (state_q == ISSUE) begin
        if (cpu_res.ready) begin
          req_q.valid <= 1'b0;
          done_cnt    <= done_cnt + 32'd1;
          if (cur_query_q) begin
            rd_valid     <= 1'b1;
            rd_data      <= cpu_res.data;
            rd_client_id <= cur_id_q;
          end
        end else begin
          // Never abort: the cache may be mid-allocate or mid-write-back.
          if (stall_cnt != SCW'(STALL_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
          if (stall_cnt == SCW'(STALL_LIMIT - 1)) stall_err <= 1'b1;
        end
      end
    end
  end

  assign cpu_req = req_q;
  assign busy    = (fifo_cnt != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_cancel_req_sequencer.sv
module tb_cancel_req_sequencer;
  import cancel_req_sequencer_pkg::*;

  localparam int IDW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_is_query = 1'b0;
  logic [IDW-1:0] in_client_id = '0;
  logic [31:0]    in_qty = '0;
  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  logic           rd_valid;
  logic [IDW-1:0] rd_client_id;
  logic [31:0]    rd_data;
  logic           busy, stall_err;
  logic [31:0]    done_cnt;

  cancel_req_sequencer #(.DEPTH(8), .IDW(IDW), .STALL_LIMIT(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_query(in_is_query), .in_client_id(in_client_id), .in_qty(in_qty),
    .cpu_req(cpu_req), .cpu_res(cpu_res), .rd_valid(rd_valid),
    .rd_client_id(rd_client_id), .rd_data(rd_data), .busy(busy),
    .stall_err(stall_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cache model: accumulates writes per client, answers reads with the
  // balance. ready is combinational once valid has been up lat+1 cycles,
  // so lat=0 is a hit. hold stalls it forever; spur injects stray ready.
  logic [31:0] bal [1024];
  int          lat = 0;
  int          wait_cnt = 0;
  logic        hold = 1'b0, spur = 1'b0;
  logic        mdl_rdy;
  logic [9:0]  req_id;

  assign req_id  = cpu_req.addr[11:2];
  assign mdl_rdy = cpu_req.valid && !hold && (wait_cnt >= lat);

  always_comb begin
    cpu_res       = '0;
    cpu_res.data  = bal[req_id];
    cpu_res.ready = mdl_rdy || spur;
  end

  always @(posedge clk) begin
    if (!cpu_req.valid || mdl_rdy) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mdl_rdy && cpu_req.rw) bal[req_id] <= bal[req_id] + cpu_req.data;
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          vwin, cur_len, last_len, stab_err, rd_cnt, n_done;
  logic [31:0] addr_log [16];
  logic [31:0] data_log [16];
  logic        rw_log [16];
  int          rise_cyc [16];
  logic [9:0]  done_ids [16];
  logic [31:0] last_rd_data;
  logic [9:0]  last_rd_id;
  cpu_req_type prev_req;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      vwin = 0; cur_len = 0; last_len = 0; stab_err = 0; rd_cnt = 0; n_done = 0;
      last_rd_data = '0; last_rd_id = '0; prev_req = '0;
    end else begin
      if (cpu_req.valid && !prev_req.valid) begin
        if (vwin < 16) begin
          addr_log[vwin] = cpu_req.addr; data_log[vwin] = cpu_req.data;
          rw_log[vwin] = cpu_req.rw; rise_cyc[vwin] = cyc;
        end
        vwin++;
        cur_len = 1;
      end else if (cpu_req.valid) begin
        cur_len++;
        if (cpu_req != prev_req) stab_err++;
      end
      if (!cpu_req.valid && prev_req.valid) last_len = cur_len;
      if (cpu_req.valid && cpu_res.ready) begin
        if (n_done < 16) done_ids[n_done] = req_id;
        n_done++;
      end
      if (rd_valid) begin
        rd_cnt++; last_rd_data = rd_data; last_rd_id = rd_client_id;
      end
      prev_req = cpu_req;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; spur = 1'b0; lat = 0;
    for (int i = 0; i < 1024; i++) bal[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic q, input logic [IDW-1:0] id, input logic [31:0] qty);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_is_query = q; in_client_id = id; in_qty = qty;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  int acc;

  initial begin
    do_reset();

    // Reset state
    chk("rst_req", cpu_req, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rd", {rd_valid, rd_client_id, rd_data}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall_err, 1'b0);
    chk("rst_done", done_cnt, 32'd0);

    // Single write, compulsory miss (4 extra cycles)
    lat = 4;
    push(1'b0, 10'd5, 32'd100);
    wait_idle(100);
    chk("w1_windows", vwin, 1);
    chk("w1_addr", addr_log[0], 32'h14);
    chk("w1_rw", rw_log[0], 1'b1);
    chk("w1_data", data_log[0], 32'd100);
    chk("w1_len", last_len, 5);
    chk("w1_done", done_cnt, 32'd1);
    chk("w1_stable", stab_err, 0);

    // Accumulate then query, all hits
    do_reset();
    push(1'b0, 10'd5, 32'd100);
    push(1'b0, 10'd5, 32'd23);
    push(1'b1, 10'd5, 32'd999);
    wait_idle(100);
    chk("aq_rd_cnt", rd_cnt, 1);
    chk("aq_rd_id", last_rd_id, 10'd5);
    chk("aq_rd_data", last_rd_data, 32'd123);
    chk("aq_qdata", data_log[2], 32'd0);
    chk("aq_qrw", rw_log[2], 1'b0);
    chk("aq_hit_len", last_len, 1);
    chk("aq_gap1", rise_cyc[1] - rise_cyc[0], 3);
    chk("aq_gap2", rise_cyc[2] - rise_cyc[1], 3);
    chk("aq_done", done_cnt, 32'd3);
    // Stray ready while idle must be ignored
    @(negedge clk); spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_done", done_cnt, 32'd3);
    chk("spur_valid", cpu_req.valid, 1'b0);

    // FIFO full: one entry is popped into ISSUE right away, so DEPTH+1 are
    // accepted before in_ready drops.
    do_reset();
    hold = 1'b1;
    acc = 0;
    @(negedge clk);
    while (in_ready && acc < 12) begin
      in_valid = 1'b1; in_is_query = 1'b0;
      in_client_id = IDW'(10 + acc); in_qty = 32'(acc + 1);
      acc++;
      @(negedge clk);
    end
    in_client_id = IDW'(10 + acc);
    repeat (4) @(negedge clk);
    chk("full_accepted", acc, 9);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    chk("full_no_done", done_cnt, 32'd0);
    in_valid = 1'b0;
    hold = 1'b0;
    wait_idle(200);
    chk("full_done", done_cnt, 32'd9);
    for (int i = 0; i < 9; i++) chk("full_order", done_ids[i], 10'(10 + i));
    chk("full_stable", stab_err, 0);

    // Stall: cache never answers
    do_reset();
    hold = 1'b1;
    push(1'b0, 10'd7, 32'd9);
    acc = 0;
    while (!cpu_req.valid && acc < 20) begin @(negedge clk); acc++; end
    repeat (1023) @(negedge clk);
    chk("stall_pre", stall_err, 1'b0);
    @(negedge clk);
    chk("stall_set", stall_err, 1'b1);
    repeat (5) @(negedge clk);
    chk("stall_sticky", stall_err, 1'b1);
    chk("stall_valid", cpu_req.valid, 1'b1);
    chk("stall_addr", cpu_req.addr, 32'h1c);
    chk("stall_data", cpu_req.data, 32'd9);
    chk("stall_stable", stab_err, 0);
    chk("stall_busy", busy, 1'b1);

    // Reset mid-ISSUE with 3 entries queued
    do_reset();
    hold = 1'b1;
    push(1'b0, 10'd3, 32'd1);
    push(1'b1, 10'd3, 32'd0);
    push(1'b0, 10'd4, 32'd2);
    push(1'b1, 10'd4, 32'd0);
    @(negedge clk);
    chk("mid_pre_valid", cpu_req.valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hold = 1'b0;
    chk("mid_valid", cpu_req.valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done_cnt, 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_no_rd", rd_cnt, 0);
    chk("mid_no_replay", vwin, 0);
    chk("mid_done_after", done_cnt, 32'd0);

    // Conflicting addresses with long (write-back + allocate) latency
    do_reset();
    lat = 10;
    push(1'b0, 10'h001, 32'd5);
    push(1'b0, 10'h301, 32'd7);
    wait_idle(200);
    chk("conf_done", done_cnt, 32'd2);
    chk("conf_windows", vwin, 2);
    chk("conf_addr0", addr_log[0], 32'h4);
    chk("conf_addr1", addr_log[1], 32'hc04);
    chk("conf_len", last_len, 11);
    chk("conf_stall", stall_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
